// File: rtl/wbuf_pkg.sv
// Shared constants, state type and block layout for the WBUF write path.
package wbuf_pkg;

  localparam int unsigned N_BANK     = 6;
  localparam int unsigned DEPTH      = 11;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned IN_W       = 64;
  localparam int unsigned BEATS      = DATA_W / IN_W;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned ADDR_W     = $clog2(DEPTH);
  localparam int unsigned BANK_W     = $clog2(N_BANK);
  localparam int unsigned MAX_BLOCKS = N_BANK * DEPTH;
  localparam int unsigned CNT_W      = $clog2(MAX_BLOCKS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  // Layout contract with the read-side controller: block k lives in
  // bank (k mod N_BANK) at address (k div N_BANK), i.e. blocks are striped
  // across banks first and only then advance in address.
  function automatic logic [BANK_W-1:0] blk_bank(input logic [CNT_W-1:0] k);
    return BANK_W'(k % CNT_W'(N_BANK));
  endfunction

  function automatic logic [ADDR_W-1:0] blk_addr(input logic [CNT_W-1:0] k);
    return ADDR_W'(k / CNT_W'(N_BANK));
  endfunction

endpackage

// File: rtl/wbuf_block_packer.sv
// Collects BEATS input beats into one DATA_W block, beat 0 in the LSBs.
module wbuf_block_packer
  import wbuf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              beat_valid_i,
  input  logic [IN_W-1:0]   beat_data_i,
  output logic              blk_valid_c,
  output logic [DATA_W-1:0] blk_data_c
);

  logic [BEAT_W-1:0]        beat_cnt_q;
  logic [DATA_W-IN_W-1:0]   pack_q;

  // The last beat is not stored; it is merged straight into the block so the
  // block is available in the same cycle as its final handshake.
  assign blk_valid_c = beat_valid_i && (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign blk_data_c  = {beat_data_i, pack_q};

  // Beat counter and insert register; contents hold across input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      pack_q     <= '0;
    end else if (clr_i) begin
      beat_cnt_q <= '0;
    end else if (beat_valid_i) begin
      beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      for (int unsigned i = 0; i < BEATS - 1; i++) begin
        if (beat_cnt_q == BEAT_W'(i)) pack_q[i*IN_W +: IN_W] <= beat_data_i;
      end
    end
  end

endmodule

// File: rtl/wbuf_loader.sv
// Streams 64-bit weight beats into 4x4 blocks and writes them across the WBUF banks.
module wbuf_loader
  import wbuf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              s_valid,
  input  logic [IN_W-1:0]   s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    block_cnt_q;
  logic [BANK_W-1:0]   bank_cnt_q;
  logic [ADDR_W-1:0]   addr_cnt_q;
  logic                s_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                wr_en_q;
  logic [BANK_W-1:0]   wr_bank_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                blk_valid_c;
  logic [DATA_W-1:0]   blk_data_c;
  logic                legal_c;

  assign legal_c = (num_blocks != '0) && (num_blocks <= CNT_W'(MAX_BLOCKS));

  // Packer is held empty outside LOAD so a new load always starts at beat 0.
  wbuf_block_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (state_q == IDLE),
    .beat_valid_i (s_valid && s_ready_q),
    .beat_data_i  (s_data),
    .blk_valid_c  (blk_valid_c),
    .blk_data_c   (blk_data_c)
  );

  // Load FSM, bank/address/block counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      block_cnt_q <= '0;
      bank_cnt_q  <= '0;
      addr_cnt_q  <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (legal_c) begin
              num_q       <= num_blocks;
              block_cnt_q <= '0;
              bank_cnt_q  <= '0;
              addr_cnt_q  <= '0;
              s_ready_q   <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (blk_valid_c) begin
            wr_en_q     <= 1'b1;
            wr_data_q   <= blk_data_c;
            wr_bank_q   <= bank_cnt_q;
            wr_addr_q   <= addr_cnt_q;
            block_cnt_q <= block_cnt_q + CNT_W'(1);
            if (bank_cnt_q == BANK_W'(N_BANK - 1)) begin
              bank_cnt_q <= '0;
              addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
            end else begin
              bank_cnt_q <= bank_cnt_q + BANK_W'(1);
            end
            if (block_cnt_q == num_q - CNT_W'(1)) begin
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wr_en   = wr_en_q;
  assign wr_bank = wr_bank_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
